// File: rtl/e_gpu_conf_regs_if.sv
// OBI request/response channels for the e-GPU configuration port.
interface obi_req_if;
  logic        req;
  logic        we;
  logic [3:0]  be;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        gnt;

  modport master (
    output req, we, be, addr, wdata,
    input  gnt
  );
  modport slave (
    input  req, we, be, addr, wdata,
    output gnt
  );
endinterface

interface obi_rsp_if;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (input rvalid, rdata);
  modport slave (output rvalid, rdata);
endinterface

// File: rtl/e_gpu_conf_regs.sv
// e-GPU configuration registers: CTRL/START/IRQ_CLR/STATUS/KERNEL_PC/CYCLES.
// Define E_GPU_CONF_REGS_PERF_EN to add the saturating CYCLES counter.
module e_gpu_conf_regs #(
  parameter logic [31:0] BOOT_ADDR = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  obi_req_if.slave    conf_regs_req,
  obi_rsp_if.slave    conf_regs_rsp,
  output logic        gpu_en_o,
  output logic [31:0] kernel_pc_o,
  output logic        start_o,
  input  logic        kernel_done_i,
  output logic        busy_o,
  output logic        interrupt_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    DONE    = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        en_q;
  logic [31:0] pc_q;
  logic        start_q;
  logic        rvalid_q;
  logic [31:0] rdata_q;
  logic [31:0] rd_data;

  logic        hs, wr, rd;
  logic [5:0]  off;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        ctrl_wr, en_clr, start_req, clr_req, pc_wr;
  logic        launch;
  logic        unused_addr;

  assign conf_regs_req.gnt = conf_regs_req.req;

  assign hs    = conf_regs_req.req & conf_regs_req.gnt;
  assign wr    = hs & conf_regs_req.we;
  assign rd    = hs & ~conf_regs_req.we;
  assign off   = conf_regs_req.addr[7:2];
  assign be    = conf_regs_req.be;
  assign wdata = conf_regs_req.wdata;

  // Register window aliases every 256 B.
  assign unused_addr = ^{conf_regs_req.addr[31:8],
                         conf_regs_req.addr[1:0]};

  assign ctrl_wr   = wr & (off == 6'h00) & be[0];
  assign en_clr    = ctrl_wr & ~wdata[0];
  assign start_req = wr & (off == 6'h01) & be[0] & wdata[0];
  assign clr_req   = wr & (off == 6'h02) & be[0] & wdata[0];
  assign pc_wr     = wr & (off == 6'h04);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // EN-clear overrides every other event, including kernel_done_i.
  always_comb begin
    state_d = state_q;
    if (en_clr) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    if (start_req && en_q) state_d = RUNNING;
        RUNNING: if (kernel_done_i)     state_d = DONE;
        DONE:    if (clr_req)           state_d = IDLE;
        default:                        state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    busy_o      = (state_q == RUNNING);
    interrupt_o = (state_q == DONE);
  end

  assign launch = (state_q == IDLE) && (state_d == RUNNING);

`ifdef E_GPU_CONF_REGS_PERF_EN
  logic [31:0] cycles_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cycles_q <= '0;
    end else if (launch) begin
      cycles_q <= '0;
    end else if (state_q == RUNNING && cycles_q != '1) begin
      cycles_q <= cycles_q + 32'd1;
    end
  end
`endif

  always_comb begin
    rd_data = '0;
    case (off)
      6'h00: rd_data[0]   = en_q;
      6'h03: rd_data[2:0] = {en_q, interrupt_o, busy_o};
      6'h04: rd_data      = pc_q;
`ifdef E_GPU_CONF_REGS_PERF_EN
      6'h05: rd_data      = cycles_q;
`endif
      default: rd_data    = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      en_q     <= 1'b0;
      pc_q     <= BOOT_ADDR;
      start_q  <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      if (ctrl_wr) en_q <= wdata[0];
      for (int i = 0; i < 4; i++) begin
        if (pc_wr && be[i]) pc_q[8*i +: 8] <= wdata[8*i +: 8];
      end
      start_q  <= launch;
      rvalid_q <= hs;
      rdata_q  <= rd ? rd_data : '0;
    end
  end

  assign gpu_en_o             = en_q;
  assign kernel_pc_o          = pc_q;
  assign start_o              = start_q;
  assign conf_regs_rsp.rvalid = rvalid_q;
  assign conf_regs_rsp.rdata  = rdata_q;

endmodule

// File: doc/e_gpu_conf_regs.md
# e_gpu_conf_regs

OBI responder implementing the e-GPU configuration register file: the target of the host's `conf_regs_req`/`conf_regs_rsp` accesses. Decodes host reads and writes, holds the GPU enable and kernel start address, issues a one-cycle kernel start pulse, tracks kernel execution, and raises and clears the host interrupt. Sits inside `e_gpu` between the host-facing config port and the GPU dispatch logic.

## Interface
- `BOOT_ADDR`, default 32'h0000_0000: reset value of KERNEL_PC.
- `clk_i`  in  1  clock, rising edge.
- `rst_ni`  in  1  reset; asynchronous, active-low.
- `conf_regs_req`  obi_req_if (slave side)  host request: `req`, `we`, `be[3:0]`, `addr[31:0]`, `wdata[31:0]` in; `gnt` out.
- `conf_regs_rsp`  obi_rsp_if (slave side)  response: `rvalid`, `rdata[31:0]` out.
- `gpu_en_o`  out  1  CTRL.EN; GPU core enable.
- `kernel_pc_o`  out  32  KERNEL_PC register.
- `start_o`  out  1  one-cycle kernel launch pulse.
- `kernel_done_i`  in  1  one-cycle pulse from GPU, kernel finished.
- `busy_o`  out  1  state == RUNNING.
- `interrupt_o`  out  1  state == DONE.

## Operation
- Register map, decoded on `addr[7:2]`. `addr[31:8]` is ignored, so addresses alias every 256 B.
  - 0x00 CTRL: RW. bit0 EN, reset 0. Other bits read 0.
  - 0x04 START: write with `be[0]` and `wdata[0]=1` requests a launch. Reads 0.
  - 0x08 IRQ_CLR: write with `be[0]` and `wdata[0]=1` requests a clear. Reads 0.
  - 0x0C STATUS: RO. bit0 busy, bit1 done, bit2 EN.
  - 0x10 KERNEL_PC: RW, per-byte `be`. Reset `BOOT_ADDR`.
  - 0x14 CYCLES: RO; see Configuration.
  - Unmapped offsets: writes ignored, reads return 0. There is no error response.
- State machine, reset state IDLE:
  - IDLE -> RUNNING on an accepted START write with EN=1. `start_o` pulses.
  - START with EN=0 is ignored.
  - RUNNING -> DONE on `kernel_done_i`.
  - DONE -> IDLE on an accepted IRQ_CLR write.
  - START in RUNNING or DONE is ignored. IRQ_CLR in IDLE or RUNNING is ignored.
  - `kernel_done_i` in IDLE or DONE is ignored.
  - A CTRL write with EN=0 forces IDLE from any state. No interrupt, no start.
- Simultaneous events:
  - `kernel_done_i` and IRQ_CLR in RUNNING: done wins, state goes to DONE.
  - `kernel_done_i` and EN-clear: EN-clear wins, state goes to IDLE.
  - A single write sets CTRL.EN=1 and the following START is accepted.

## Timing
- `gnt` is combinational, equal to `req`. Zero wait states; every request is granted in its request cycle.
- Write data is committed at the clock edge ending the handshake cycle (`req & gnt`).
- `rvalid` is registered, high for exactly one cycle, the cycle after each handshake. Reads and writes both respond.
- `rdata` is valid only with `rvalid`: the value sampled at the handshake edge for reads, 0 for writes. It is 0 when `rvalid` is low.
- Back-to-back requests are accepted every cycle. There is one response per request, in order.
- `start_o`, `busy_o` and `interrupt_o` are registered and reflect the new state in the cycle after the commit edge. `start_o` is high for one cycle.
- `interrupt_o` rises the cycle after `kernel_done_i` is sampled. It falls the cycle after the IRQ_CLR handshake, coinciding with that write's `rvalid`.
- Reset values:
  - `gnt` = `req`; `rvalid` = 0; `rdata` = 0.
  - `gpu_en_o` = 0; `kernel_pc_o` = `BOOT_ADDR`.
  - `start_o` = 0; `busy_o` = 0; `interrupt_o` = 0.
- Reset asserted mid-transaction drops any pending `rvalid` immediately and returns to IDLE. The host must reissue the access.

## Configuration
- `E_GPU_CONF_REGS_PERF_EN` defined:
  - 32-bit cycle counter, cleared on the START that enters RUNNING.
  - Increments every cycle in RUNNING and holds in DONE and IDLE.
  - Saturates at 32'hFFFF_FFFF. Readable at 0x14.
- Undefined: no counter logic; 0x14 reads 0.

## Test plan
- Reset, then read 0x00, 0x0C and 0x10 -> each `rvalid` arrives one cycle after `gnt`; rdata 0, 0, `BOOT_ADDR`. All outputs at reset values.
- Write 0x00=1, then 0x04=1 -> `gpu_en_o`=1; one-cycle `start_o`; STATUS reads 0x5. Pulse `kernel_done_i` -> `interrupt_o`=1 next cycle, STATUS=0x6. Write 0x08=1 -> `interrupt_o`=0, STATUS=0x4.
- Write 0x04=1 with EN=0 -> no `start_o`, STATUS=0. Write KERNEL_PC=0x1234_5678 with be=4'b0011, starting from 0 -> reads 0x0000_5678.
- In RUNNING, drive `kernel_done_i` in the same cycle as an IRQ_CLR handshake -> DONE, `interrupt_o`=1. In RUNNING, write CTRL=0 with `kernel_done_i` -> IDLE, `interrupt_o`=0.
- Issue back-to-back requests: write 0x10, read 0x10, read 0x3C -> three `rvalid` pulses on consecutive cycles, with rdata 0, written value, 0. Assert `rst_ni` low during a pending response -> `rvalid` drops immediately.
- With `E_GPU_CONF_REGS_PERF_EN`: START, then `kernel_done_i` 100 cycles later -> CYCLES reads 100. Without the macro, 0x14 reads 0.
